m_mux4way16_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 16-bit, 4-way multiplexer datapath. Four requesters each present a 16-bit word and a request line. The block grants the datapath to one requester at a time, drives the mux select pair, and exposes the selected word with a valid flag. It sits between the requesting units and any downstream consumer of the shared 16-bit bus.

---
 rtl/m_mux4way16_arb_pkg.sv | 26 ++
 rtl/m_mux4way16_arbiter_pick.sv | 31 +++
 rtl/m_mux4way16_arbiter.sv | 137 +++++++++++++
 tb/tb_m_mux4way16_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/m_mux4way16_arb_pkg.sv
// Shared types and select encodings for the 4-way 16-bit mux arbiter.
// Used by m_mux4way16_arbiter (optional hold timeout: M_MUX4WAY16_ARB_TIMEOUT_EN).
package m_mux4way16_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    // Input is expected to be one-hot; lowest set bit wins otherwise.
    function automatic logic [1:0] onehot_to_sel(input logic [3:0] oh);
        logic [1:0] sel;
        sel = SEL_A;
        if (oh[3]) sel = SEL_D;
        if (oh[2]) sel = SEL_C;
        if (oh[1]) sel = SEL_B;
        if (oh[0]) sel = SEL_A;
        return sel;
    endfunction

endpackage

// File: rtl/m_mux4way16_arbiter_pick.sv
// Combinational round-robin picker: searches from ptr_i+1 upward, wrapping 3 -> 0,
// skipping any requester set in excl_i.
module m_rr_pick4
    import m_mux4way16_arb_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    input  logic [3:0] excl_i,
    output logic [3:0] winner_o,
    output logic       found_o
);

    logic [3:0] cand;
    logic [1:0] idx;

    assign cand = req_i & ~excl_i;

    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        idx      = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_i + 2'(i);
            if (!found_o && cand[idx]) begin
                winner_o[idx] = 1'b1;
                found_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/m_mux4way16_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 16-bit 4-way mux.
// Define M_MUX4WAY16_ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no grant; o_valid low, selects hold their last value
// ST_BUSY | grant held on one requester; o_valid high
module m_mux4way16_arbiter
    import m_mux4way16_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_req,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [15:0] i_c,
    input  logic [15:0] i_d,
    output logic [3:0]  o_grant,
    output logic        o_sel1,
    output logic        o_sel2,
    output logic [15:0] o_out,
    output logic        o_valid
);

    localparam int               CNT_W   = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       sel_q,   sel_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [3:0] pick_excl;
    logic [3:0] pick_winner;
    logic       pick_found;
    logic       holder_req;
    logic       others_req;
    logic       hold_expired;

    assign holder_req = |(i_req & grant_q);
    assign others_req = |(i_req & ~grant_q);
    assign pick_excl  = (state_q == ST_BUSY) ? grant_q : 4'b0000;

    m_rr_pick4 u_pick (
        .req_i    (i_req),
        .ptr_i    (ptr_q),
        .excl_i   (pick_excl),
        .winner_o (pick_winner),
        .found_o  (pick_found)
    );

`ifdef M_MUX4WAY16_ARB_TIMEOUT_EN
    assign hold_expired = (cnt_q == CNT_MAX) && others_req;
`else
    logic unused_hold;
    assign unused_hold  = ^{cnt_q, others_req};
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_found) begin
                    state_d = ST_BUSY;
                    grant_d = pick_winner;
                    sel_d   = onehot_to_sel(pick_winner);
                    ptr_d   = onehot_to_sel(pick_winner);
                end
            end
            ST_BUSY: begin
                if (holder_req && !hold_expired) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (pick_found) begin
                    // Release or timeout with a waiter: hand over on this edge.
                    grant_d = pick_winner;
                    sel_d   = onehot_to_sel(pick_winner);
                    ptr_d   = onehot_to_sel(pick_winner);
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = 4'b0000;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            grant_q <= 4'b0000;
            sel_q   <= SEL_A;
            ptr_q   <= SEL_D;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_grant = grant_q;
    assign o_sel1  = sel_q[1];
    assign o_sel2  = sel_q[0];
    assign o_valid = (state_q == ST_BUSY);

    always_comb begin
        o_out = 16'h0000;
        if (o_valid) begin
            case (sel_q)
                SEL_A:   o_out = i_a;
                SEL_B:   o_out = i_b;
                SEL_C:   o_out = i_c;
                default: o_out = i_d;
            endcase
        end
    end

endmodule

// File: tb/tb_m_mux4way16_arbiter.sv
// Scoreboard bench for m_mux4way16_arbiter (MAX_HOLD=4); the reference model
// follows M_MUX4WAY16_ARB_TIMEOUT_EN the same way the build does.
module tb_m_mux4way16_arbiter;

    localparam int MAXH = 4;
`ifdef M_MUX4WAY16_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]  grant;
        logic [1:0]  sel;
        logic        valid;
        logic [15:0] out;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [3:0]  i_req;
    logic [15:0] i_a, i_b, i_c, i_d;
    logic [3:0]  o_grant;
    logic        o_sel1, o_sel2;
    logic [15:0] o_out;
    logic        o_valid;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    logic [3:0] m_grant;
    logic [1:0] m_sel;
    logic [1:0] m_ptr;
    int         m_cnt;

    always #5 i_clk = ~i_clk;

    m_mux4way16_arbiter #(.MAX_HOLD(MAXH)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_c     (i_c),
        .i_d     (i_d),
        .o_grant (o_grant),
        .o_sel1  (o_sel1),
        .o_sel2  (o_sel2),
        .o_out   (o_out),
        .o_valid (o_valid)
    );

    task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic [3:0] req);
        int hold;
        bit expired;
        bit found;
        int idx;
        if (rst) begin
            m_grant = 4'b0000;
            m_sel   = 2'b00;
            m_ptr   = 2'b11;
            m_cnt   = 0;
            return;
        end
        hold = -1;
        for (int i = 0; i < 4; i++) if (m_grant[i]) hold = i;
        expired = TO_EN && (hold >= 0) && (m_cnt == MAXH - 1) && ((req & ~m_grant) != 4'b0000);
        if (hold >= 0 && req[hold] && !expired) begin
            if (m_cnt < MAXH - 1) m_cnt++;
        end else begin
            found = 1'b0;
            for (int j = 1; j <= 4; j++) begin
                idx = (int'(m_ptr) + j) % 4;
                if (!found && req[idx] && idx != hold) begin
                    found   = 1'b1;
                    m_grant = 4'b0001 << idx;
                    m_sel   = 2'(idx);
                    m_ptr   = 2'(idx);
                    m_cnt   = 0;
                end
            end
            if (!found) begin
                m_grant = 4'b0000;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic compare_one();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_val("grant", 16'(o_grant), 16'(e.grant));
            chk_val("sel",   16'({o_sel1, o_sel2}), 16'(e.sel));
            chk_val("valid", 16'(o_valid), 16'(e.valid));
            chk_val("out",   o_out, e.out);
        end
    endtask

    task automatic cyc(input logic rst, input logic [3:0] req,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
        exp_t e;
        @(negedge i_clk);
        compare_one();
        i_rst = rst;
        i_req = req;
        i_a = a; i_b = b; i_c = c; i_d = d;
        model_step(rst, req);
        e.grant = m_grant;
        e.sel   = m_sel;
        e.valid = (m_grant != 4'b0000);
        case (m_sel)
            2'b00:   e.out = a;
            2'b01:   e.out = b;
            2'b10:   e.out = c;
            default: e.out = d;
        endcase
        if (!e.valid) e.out = 16'h0000;
        sb.push_back(e);
    endtask

    task automatic cyc_std(input logic rst, input logic [3:0] req);
        cyc(rst, req, 16'hA5A5, 16'hB0B1, 16'hC2C3, 16'hD4D5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        i_req = 4'b0000;
        i_a = '0; i_b = '0; i_c = '0; i_d = '0;
        model_step(1'b1, 4'b0000);

        // Reset held with all requests up, then release.
        repeat (3) cyc_std(1'b1, 4'b1111);
        cyc_std(1'b0, 4'b1111);

        // Each holder drops for one cycle after a single grant.
        repeat (5) cyc_std(1'b0, 4'b1111 & ~m_grant);

        // Handover c -> b in one edge.
        cyc_std(1'b0, 4'b0000);
        cyc_std(1'b0, 4'b0100);
        cyc_std(1'b0, 4'b0100);
        cyc_std(1'b0, 4'b0010);
        cyc_std(1'b0, 4'b0010);
        cyc_std(1'b0, 4'b0000);

        // a holds, d joins one cycle later.
        cyc_std(1'b1, 4'b0000);
        cyc_std(1'b0, 4'b0001);
        repeat (8) cyc_std(1'b0, 4'b1001);
        repeat (3) cyc_std(1'b0, 4'b1000);
        cyc_std(1'b0, 4'b0000);

        // Sole requester b.
        repeat (20) cyc_std(1'b0, 4'b0010);
        cyc_std(1'b0, 4'b0000);

        // Reset while d is granted.
        repeat (3) cyc_std(1'b0, 4'b1000);
        cyc_std(1'b1, 4'b1001);
        repeat (3) cyc_std(1'b0, 4'b1001);

        // Random traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            cyc(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
                16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end

        @(negedge i_clk);
        compare_one();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
